// File: rtl/ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// ram_responder_pkg
// Shared constants for the MI-bus memory responder:
//   - 2-bit FSM state encodings
//   - default geometry, kept consistent with the cache side
//     (line address = c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE, word = c_RAM_DATA_SIZE)
//   - width helper for the beat counter
// ---------------------------------------------------------------------------
package ram_responder_pkg;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_WAIT        = 2'd1;
    localparam logic [1:0] ST_READ_BURST  = 2'd2;
    localparam logic [1:0] ST_WRITE_BURST = 2'd3;

    localparam int DEF_ADDR_SIZE = 10;  // tag + index bits of the CPU address
    localparam int DEF_DATA_SIZE = 32;  // MI data word
    localparam int DEF_BURST_LEN = 4;   // words per line
    localparam int DEF_LATENCY   = 3;   // request acceptance to first beat

    // A one-word burst still needs a 1-bit counter to keep vectors legal.
    function automatic int beat_cnt_width(input int burst_len);
        return (burst_len > 1) ? $clog2(burst_len) : 1;
    endfunction

endpackage

// File: rtl/ram_array.sv
// ---------------------------------------------------------------------------
// ram_array
// Synchronous single-port backing store with registered read.
// Contents are never cleared; reset does not reach this block.
//   clk    in   clock, rising edge
//   we     in   write enable (write wdata to addr)
//   addr   in   word address (shared by read and write)
//   wdata  in   write data
//   rdata  out  registered read data of the address sampled at the last edge
// ---------------------------------------------------------------------------
module ram_array
    import ram_responder_pkg::*;
#(
    parameter int AW = DEF_ADDR_SIZE + 2,
    parameter int DW = DEF_DATA_SIZE
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_responder.sv
// ---------------------------------------------------------------------------
// ram_responder
// Memory-side responder for the cache MI bus. Serves line reads and line
// writes as bursts of BURST_LEN words after a fixed LATENCY, one ACK per beat.
//
// Optional build macro: RAM_RESP_WAIT_STATE_EN
//   defined   -> one ACK-low cycle between consecutive beats
//   undefined -> back-to-back beats
//
// Ports:
//   CLK             in   clock, rising edge
//   RESET           in   asynchronous active-high reset
//   MI_ADDR         in   line address, sampled with the request
//   SIG_RAM_RD      in   read-line request (level, sampled only when idle)
//   SIG_RAM_WR      in   write-line request (level, sampled only when idle)
//   MI_IN_DATA      in   write data, beat k valid while ACK is high for beat k
//   MI_OUT_DATA     out  read data, zero whenever ACK is low
//   MI_SIG_RAM_ACK  out  one-cycle strobe per beat
//   BUSY            out  high from acceptance through the last beat
//   ERR             out  one-cycle pulse on RD and WR requested together
//
// The state register runs one cycle ahead of ACK: a burst state in cycle c
// means the beat strobe is registered at the edge ending c. That lead lets
// the array read be issued early enough for MI_OUT_DATA to stay registered.
// ---------------------------------------------------------------------------
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [ADDR_SIZE-1:0] MI_ADDR,
    input  logic                 SIG_RAM_RD,
    input  logic                 SIG_RAM_WR,
    input  logic [DATA_SIZE-1:0] MI_IN_DATA,
    output logic [DATA_SIZE-1:0] MI_OUT_DATA,
    output logic                 MI_SIG_RAM_ACK,
    output logic                 BUSY,
    output logic                 ERR
);

    localparam int BEAT_W     = beat_cnt_width(BURST_LEN);
    localparam int BEAT_SHIFT = $clog2(BURST_LEN);
    localparam int WORD_AW    = ADDR_SIZE + BEAT_SHIFT;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [3:0]        LAT_LOAD  = 4'(LATENCY - 1);

    // {line address, beat index}; with a one-word burst the beat bit is 0.
    function automatic logic [WORD_AW-1:0] word_addr(
        input logic [ADDR_SIZE-1:0] line,
        input logic [BEAT_W-1:0]    beat
    );
        return (WORD_AW'(line) << BEAT_SHIFT) | WORD_AW'(beat);
    endfunction

    logic [1:0]           state_q,    state_d;
    logic [3:0]           lat_cnt_q,  lat_cnt_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0]    ack_beat_q, ack_beat_d;
    logic [ADDR_SIZE-1:0] addr_q,     addr_d;
    logic                 wr_dir_q,   wr_dir_d;
    logic                 gap_q,      gap_d;
    logic                 ack_q,      ack_d;
    logic                 busy_q,     busy_d;
    logic                 err_q,      err_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;

    logic                 ram_we;
    logic [WORD_AW-1:0]   ram_addr;
    logic [DATA_SIZE-1:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        ack_beat_d = ack_beat_q;
        addr_d     = addr_q;
        wr_dir_d   = wr_dir_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        out_data_d = '0;

        // BUSY falls at the edge that ends the last beat.
        if (ack_q && (ack_beat_q == LAST_BEAT)) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // The state returns to IDLE during the last beat, so the
                // busy gate is what guarantees a free cycle between bursts.
                if (!busy_q) begin
                    if (SIG_RAM_RD && SIG_RAM_WR) begin
                        err_d = 1'b1;
                    end else if (SIG_RAM_RD || SIG_RAM_WR) begin
                        addr_d     = MI_ADDR;
                        wr_dir_d   = SIG_RAM_WR;
                        busy_d     = 1'b1;
                        beat_cnt_d = '0;
                        gap_d      = 1'b0;
                        if (LAT_LOAD == 4'd0) begin
                            lat_cnt_d = 4'd0;
                            state_d   = SIG_RAM_WR ? ST_WRITE_BURST : ST_READ_BURST;
                        end else begin
                            lat_cnt_d = LAT_LOAD;
                            state_d   = ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd1) begin
                    state_d = wr_dir_q ? ST_WRITE_BURST : ST_READ_BURST;
                end
            end

            ST_READ_BURST, ST_WRITE_BURST: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    ack_d      = 1'b1;
                    ack_beat_d = beat_cnt_q;
                    if (state_q == ST_READ_BURST) begin
                        out_data_d = ram_rdata;
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_IDLE;
                        beat_cnt_d = '0;
                        gap_d      = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
`ifdef RAM_RESP_WAIT_STATE_EN
                        gap_d = 1'b1;
`else
                        gap_d = 1'b0;
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes commit at the edge ending an ACK beat; otherwise the array reads
    // the word of the beat that will be strobed one edge later.
    always_comb begin
        ram_we   = ack_q && wr_dir_q;
        ram_addr = ram_we ? word_addr(addr_q, ack_beat_q)
                          : word_addr(addr_d, beat_cnt_d);
    end

    ram_array #(
        .AW (WORD_AW),
        .DW (DATA_SIZE)
    ) u_ram_array (
        .clk   (CLK),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (MI_IN_DATA),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            lat_cnt_q  <= '0;
            beat_cnt_q <= '0;
            ack_beat_q <= '0;
            addr_q     <= '0;
            wr_dir_q   <= 1'b0;
            gap_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            ack_beat_q <= ack_beat_d;
            addr_q     <= addr_d;
            wr_dir_q   <= wr_dir_d;
            gap_q      <= gap_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
        end
    end

    assign MI_OUT_DATA    = out_data_q;
    assign MI_SIG_RAM_ACK = ack_q;
    assign BUSY           = busy_q;
    assign ERR            = err_q;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
Memory-side responder for the cache's MI (memory interface) bus, on the opposite end from the cache controller. It accepts line-fill reads (SIG_RAM_RD) and line write-backs/write-throughs (SIG_RAM_WR) from the cache. It serves each request as a burst of BURST_LEN words after a fixed access latency, and signals every beat with MI_SIG_RAM_ACK. It holds the backing store, so the cache can be verified against a cycle-accurate main memory instead of hand-driven ACK/data.

Parameters:
ADDR_SIZE, 10, line address width (tag+index bits of the CPU address)
DATA_SIZE, 32, MI data word width
BURST_LEN, 4, words per line transfer; power of two, 1..16
LATENCY, 3, cycles from request acceptance to first beat; 1..15

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
MI_ADDR  in  ADDR_SIZE  line address; sampled with the request
SIG_RAM_RD  in  1  read-line request (level; sampled only in IDLE)
SIG_RAM_WR  in  1  write-line request (level; sampled only in IDLE)
MI_IN_DATA  in  DATA_SIZE  write data from cache; beat k presented while ACK is high for beat k
MI_OUT_DATA  out  DATA_SIZE  read data; valid only while ACK=1
MI_SIG_RAM_ACK  out  1  beat strobe, high one cycle per beat
BUSY  out  1  high from acceptance through last beat
ERR  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset (async, any state): state=IDLE; MI_OUT_DATA=0, MI_SIG_RAM_ACK=0, BUSY=0, ERR=0; latency/beat counters=0. Memory contents are not cleared. Reset mid-burst aborts the burst. Write beats already committed are kept.
- States: IDLE, WAIT, READ_BURST, WRITE_BURST. All outputs are registered.
- IDLE, at edge t0 with exactly one of RD/WR=1: latch MI_ADDR and direction, set BUSY=1, load the latency counter with LATENCY-1, go to WAIT. If LATENCY=1, go directly to the burst state.
- IDLE with RD=WR=1: ERR=1 for the cycle after t0, request is dropped, stay IDLE.
- WAIT: decrement each cycle. At count 0, enter READ_BURST or WRITE_BURST so that beat 0 has ACK=1 in the cycle starting at edge t0+LATENCY.
- Beat k (k=0..BURST_LEN-1) occupies the cycle starting at edge t0+LATENCY+k. Word address = {latched addr, k[log2 BURST_LEN-1:0]}; sequential order, no wrap, no critical-word-first.
- Read: MI_OUT_DATA = mem[word addr] during beat k. The array is prefetched one cycle earlier so the output stays registered. MI_OUT_DATA=0 whenever ACK=0.
- Write: MI_IN_DATA is captured at the edge that ends beat k, i.e. t0+LATENCY+k+1.
- After the last beat: IDLE and BUSY=0 at edge t0+LATENCY+BURST_LEN. A request still held high is sampled at the following edge, so there is at least one idle cycle between bursts.
- RD/WR changes while BUSY are ignored. MI_ADDR is not re-sampled during a burst.
- Counter widths: latency counter is 4 bits, beat counter is log2(BURST_LEN) bits. The beat counter wraps only at burst end.

Optional Feature:
RAM_RESP_WAIT_STATE_EN
- Defined: one ACK-low cycle is inserted between consecutive beats. Beat k starts at edge t0+LATENCY+2k. BUSY and the return to IDLE shift to match. This exercises cache tolerance of non-back-to-back ACK.
- Undefined: beats are back-to-back as above.

Decomposition:
- Shared header ram_resp_constants.vh holds:
  - State encodings (2-bit).
  - Default ADDR_SIZE, DATA_SIZE, BURST_LEN, LATENCY, consistent with the cache constants (c_RAM_DATA_SIZE, c_ADDR_TAG_SIZE + c_ADDR_INDEX_SIZE).
- One sub-module, ram_array: synchronous single-port, depth 2^ADDR_SIZE × BURST_LEN, registered read, write enable. The FSM and counters stay in ram_responder.

Test Plan:
1. Async reset mid-burst: assert RESET between clock edges during READ_BURST beat 1 -> ACK, BUSY, MI_OUT_DATA drop to 0 immediately. Next request is served from WAIT normally.
2. Write line then read back: WR at addr 'h021 with beats 'h11111111, 'h22222222, 'h33333333, 'h44444444 -> 4 ACKs at t0+3..t0+6. Then RD at 'h021 -> same 4 words in order, ACK at t0'+3..t0'+6, BUSY=0 at t0'+7.
3. Address isolation: write 'hAAAAAAAA×4 at 'h3F1, then read 'h021 -> the words from scenario 2, unchanged.
4. Illegal request: RD=WR=1 in IDLE -> ERR=1 for exactly one cycle, no ACK, BUSY=0, memory unchanged.
5. Held request: RD held high through a burst -> ignored while BUSY. A second burst is accepted one cycle after BUSY falls; exactly 8 ACKs in total.
6. Build with RAM_RESP_WAIT_STATE_EN and BURST_LEN=4, LATENCY=1 -> ACK pattern 1,0,1,0,1,0,1. Read data matches scenario 2.
